// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-channel Gray-coded pointer synchronizer.
// Each channel runs its pointer through a flop chain. It also produces a
// binary view, a change pulse and a sticky flag for changes of more than one bit.

// Per-channel lane: flop chain, binary view, change detect and sticky error.
module gray_ptr_sync_lane #(
    parameter int W      = 3,
    parameter int STAGES = 2,
    parameter int CHECK  = 1
) (
    input  logic         clk,
    input  logic         rst,        // synchronous, active-low
    input  logic         ce_i,       // warm-up complete, compare allowed
    input  logic         err_clr_i,
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] sync_gray_o,
    output logic [W-1:0] sync_bin_o,
    output logic         upd_o,
    output logic         err_o
);

    logic [STAGES-1:0][W-1:0] stg_q;
    logic [W-1:0]             prev_q;

    // Plain flop chain: no logic in front of stage 0 or between stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_q <= '0;
        end else begin
            stg_q[0] <= gray_i;
            for (int k = 1; k < STAGES; k++) begin
                stg_q[k] <= stg_q[k-1];
            end
        end
    end

    assign sync_gray_o = stg_q[STAGES-1];

    // Keep last cycle's synchronized value to detect changes.
    always_ff @(posedge clk) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= sync_gray_o;
    end

    // Gray to binary: bit i is the XOR of gray bits i..MSB.
    always_comb begin
        sync_bin_o = '0;
        for (int i = 0; i < W; i++) begin
            sync_bin_o[i] = ^(sync_gray_o >> i);
        end
    end

    assign upd_o = ce_i && (sync_gray_o != prev_q);

    if (CHECK != 0) begin : g_check
        logic [W-1:0] diff;
        logic         multi;
        logic         err_q;
        logic         err_d;

        // x & (x-1) is non-zero exactly when more than one bit is set.
        assign diff  = sync_gray_o ^ prev_q;
        assign multi = |(diff & (diff - W'(1)));

        // Sticky error: clear first so a same-cycle set takes priority.
        always_comb begin
            err_d = err_q;
            if (err_clr_i)     err_d = 1'b0;
            if (ce_i && multi) err_d = 1'b1;
        end

        // Error flag register.
        always_ff @(posedge clk) begin
            if (!rst) err_q <= 1'b0;
            else      err_q <= err_d;
        end

        assign err_o = err_q;
    end else begin : g_nocheck
        assign err_o = 1'b0;
    end

endmodule

// Top: shared warm-up counter plus an array of per-channel lanes.
module gray_ptr_sync #(
    parameter int PTR_SZ = 2,
    parameter int CH     = 2,
    parameter int STAGES = 2,
    parameter int CHECK  = 1
) (
    input  logic                     clk,
    input  logic                     rst,        // synchronous, active-low
    input  logic [CH*(PTR_SZ+1)-1:0] addr_gray,
    input  logic                     err_clr,
    output logic [CH*(PTR_SZ+1)-1:0] sync_gray,
    output logic [CH*(PTR_SZ+1)-1:0] sync_bin,
    output logic                     sync_valid,
    output logic [CH-1:0]            upd,
    output logic [CH-1:0]            err
);

    localparam int W  = PTR_SZ + 1;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] CNT_VLD = CW'(STAGES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STAGES + 1);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be 2..4");
    end
    if (CH < 1 || CH > 8) begin : g_bad_ch
        $error("gray_ptr_sync: CH must be 1..8");
    end

    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 ce;
    logic [CH-1:0][W-1:0] gray_in;
    logic [CH-1:0][W-1:0] gray_out;
    logic [CH-1:0][W-1:0] bin_out;

    // Warm-up counter saturates one past STAGES. The extra count keeps the
    // first real sample from being compared against the reset value in prev.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end

    // Warm-up counter register.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign sync_valid = (cnt_q >= CNT_VLD);
    assign ce         = (cnt_q == CNT_MAX);

    assign gray_in   = addr_gray;
    assign sync_gray = gray_out;
    assign sync_bin  = bin_out;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        gray_ptr_sync_lane #(
            .W      (W),
            .STAGES (STAGES),
            .CHECK  (CHECK)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .ce_i        (ce),
            .err_clr_i   (err_clr),
            .gray_i      (gray_in[c]),
            .sync_gray_o (gray_out[c]),
            .sync_bin_o  (bin_out[c]),
            .upd_o       (upd[c]),
            .err_o       (err[c])
        );
    end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: scoreboard bench for STAGES=2 and STAGES=4 builds fed the
// same stimulus. The model works from the history of sampled inputs.
module tb_gray_ptr_sync;

    localparam int W  = 3;
    localparam int CH = 2;
    localparam int NB = CH * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          err_clr;
    logic [NB-1:0] addr_gray;

    logic [NB-1:0] g2, b2, g4, b4;
    logic          v2, v4;
    logic [CH-1:0] u2, e2, u4, e4;

    gray_ptr_sync #(.PTR_SZ(2), .CH(2), .STAGES(2), .CHECK(1)) dut2 (
        .clk(clk), .rst(rst), .addr_gray(addr_gray), .err_clr(err_clr),
        .sync_gray(g2), .sync_bin(b2), .sync_valid(v2), .upd(u2), .err(e2));

    gray_ptr_sync #(.PTR_SZ(2), .CH(2), .STAGES(4), .CHECK(1)) dut4 (
        .clk(clk), .rst(rst), .addr_gray(addr_gray), .err_clr(err_clr),
        .sync_gray(g4), .sync_bin(b4), .sync_valid(v4), .upd(u4), .err(e4));

    typedef struct packed {
        logic [NB-1:0] g;
        logic [NB-1:0] b;
        logic          v;
        logic [CH-1:0] u;
        logic [CH-1:0] e;
    } out_t;

    typedef struct {
        out_t s2;
        out_t s4;
    } exp_t;

    exp_t          q[$];
    logic [NB-1:0] hist[$];   // inputs sampled at each edge since reset release
    logic [CH-1:0] err_m[2];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    // Synchronized value after edge e for depth s: input sampled s-1 edges earlier.
    function automatic logic [NB-1:0] sg(int s, int e);
        if (e < s) return '0;
        return hist[e-s];
    endfunction

    function automatic logic [2:0] g2b(logic [2:0] g);
        for (int b = 0; b < 8; b++) begin
            if (3'(b ^ (b >> 1)) == g) return 3'(b);
        end
        return 3'd0;
    endfunction

    function automatic logic [2:0] b2g(logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [NB-1:0] bin6(logic [NB-1:0] x);
        return {g2b(x[5:3]), g2b(x[2:0])};
    endfunction

    task automatic model(input int k, input int s, input logic clr, output out_t o);
        int            e;
        logic [NB-1:0] cur, prv, prv2;
        e    = hist.size();
        cur  = sg(s, e);
        prv  = sg(s, e - 1);
        prv2 = sg(s, e - 2);
        o.g  = cur;
        o.b  = bin6(cur);
        o.v  = (e >= s);
        if (clr) err_m[k] = '0;
        for (int c = 0; c < CH; c++) begin
            o.u[c] = (e >= s + 1) && (cur[c*W +: W] != prv[c*W +: W]);
            if ((e - 1 >= s + 1) && ($countones(prv[c*W +: W] ^ prv2[c*W +: W]) > 1))
                err_m[k][c] = 1'b1;
        end
        o.e = err_m[k];
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic step(input logic r, input logic [NB-1:0] a, input logic clr);
        exp_t x;
        @(negedge clk);
        rst       = r;
        addr_gray = a;
        err_clr   = clr;
        if (!r) begin
            hist.delete();
            err_m[0] = '0;
            err_m[1] = '0;
            x.s2 = '0;
            x.s4 = '0;
        end else begin
            hist.push_back(a);
            model(0, 2, clr, x.s2);
            model(1, 4, clr, x.s4);
        end
        q.push_back(x);
    endtask

    task automatic hold(input int n, input logic [NB-1:0] a);
        for (int i = 0; i < n; i++) step(1'b1, a, 1'b0);
    endtask

    // Monitor: every edge presents a result, compared against the scoreboard.
    initial begin
        exp_t x;
        out_t a2, a4;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x  = q.pop_front();
                a2 = {g2, b2, v2, u2, e2};
                a4 = {g4, b4, v4, u4, e4};
                checks++;
                if (a2 !== x.s2) begin
                    errors++;
                    $display("FAIL stages2 cyc=%0d got g=%b b=%b v=%b u=%b e=%b want g=%b b=%b v=%b u=%b e=%b",
                             cyc, a2.g, a2.b, a2.v, a2.u, a2.e, x.s2.g, x.s2.b, x.s2.v, x.s2.u, x.s2.e);
                end
                checks++;
                if (a4 !== x.s4) begin
                    errors++;
                    $display("FAIL stages4 cyc=%0d got g=%b b=%b v=%b u=%b e=%b want g=%b b=%b v=%b u=%b e=%b",
                             cyc, a4.g, a4.b, a4.v, a4.u, a4.e, x.s4.g, x.s4.b, x.s4.v, x.s4.u, x.s4.e);
                end
            end
        end
    end

    initial begin
        logic [NB-1:0] a;
        logic [2:0]    seq[9];
        logic [2:0]    ch;
        int            r;
        rst       = 1'b0;
        err_clr   = 1'b0;
        addr_gray = 6'b101_011;
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        // Reset with non-zero input, then warm up onto it.
        for (int i = 0; i < 3; i++) step(1'b0, 6'b101_011, 1'b0);
        hold(7, 6'b101_011);

        // Clean restart on zero, then a single-bit step on ch0.
        for (int i = 0; i < 2; i++) step(1'b0, 6'b000_000, 1'b0);
        hold(6, 6'b000_000);
        hold(6, 6'b000_001);
        // Illegal two-bit jump on ch1, hold error, then clear it.
        hold(12, 6'b011_001);
        step(1'b1, 6'b011_001, 1'b1);
        hold(4, 6'b011_001);

        // Multi-bit ch0 change with err_clr on the edge that sets the flag.
        step(1'b1, 6'b011_110, 1'b0);
        step(1'b1, 6'b011_110, 1'b0);
        step(1'b1, 6'b011_110, 1'b1);
        hold(6, 6'b011_110);
        step(1'b1, 6'b011_110, 1'b1);
        hold(3, 6'b011_110);

        // Gray count on ch0 with full wrap, one step per 4 cycles.
        for (int i = 0; i < 2; i++) step(1'b0, 6'b000_000, 1'b0);
        hold(6, 6'b000_000);
        for (int i = 0; i < 9; i++) hold(4, {3'b000, seq[i]});
        hold(4, 6'b000_000);

        // Same count, with a reset pulse in the middle.
        for (int i = 0; i < 9; i++) begin
            if (i == 4) step(1'b0, {3'b010, seq[i]}, 1'b0);
            hold(4, {3'b010, seq[i]});
        end
        hold(6, {3'b010, seq[8]});

        // Random walk: mostly legal Gray steps, occasional jumps, clears, resets.
        a = 6'b010_000;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < CH; c++) begin
                ch = a[c*W +: W];
                r  = $urandom_range(0, 99);
                if (r < 20)      ch = b2g(g2b(ch) + 3'd1);
                else if (r < 30) ch = b2g(g2b(ch) - 3'd1);
                else if (r < 33) ch = 3'($urandom_range(0, 7));
                a[c*W +: W] = ch;
            end
            step(($urandom_range(0, 199) != 0), a, ($urandom_range(0, 19) == 0));
        end
        hold(3, a);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
